// File: rtl/mem2_wr_pkg.sv
// Shared types and default sizing for the memory2 write-side controller.
// Used by mem2_level_ctr and mem2_burst_writer.
package mem2_wr_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LOC        = 64;
  localparam int DEF_ADD_WIDTH  = 6;
  localparam int DEF_BURST      = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_DONE
  } wr_state_e;

endpackage

// File: rtl/mem2_level_ctr.sv
// Saturating up/down occupancy counter for memory2.
// Raises underflow/overflow strobes for the optional error checker.
module mem2_level_ctr
  import mem2_wr_pkg::*;
#(
  parameter int LOC = DEF_LOC,
  parameter int AW  = DEF_ADD_WIDTH
) (
  input  logic        rclk,
  input  logic        rst,
  input  logic        inc,
  input  logic        dec,
  output logic [AW:0] level,
  output logic        full,
  output logic        empty,
  output logic        udf,
  output logic        ovf
);

  localparam logic [AW:0] LOC_V = (AW+1)'(LOC);
  localparam logic [AW:0] ONE   = (AW+1)'(1);

  assign full  = (level == LOC_V);
  assign empty = (level == '0);
  assign udf   = dec && empty;
  assign ovf   = inc && full;

  // inc and dec together cancel out
  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      level <= '0;
    end else if (inc && !dec && !full) begin
      level <= level + ONE;
    end else if (dec && !inc && !empty) begin
      level <= level - ONE;
    end
  end

endmodule

// File: rtl/mem2_burst_writer.sv
// Burst write controller feeding memory2; reserves BURST slots per burst.
// Define MEM2_WR_OVF_CHK_EN to enable the sticky underflow/overflow err flag.
module mem2_burst_writer
  import mem2_wr_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LOC        = DEF_LOC,
  parameter int ADD_WIDTH  = DEF_ADD_WIDTH,
  parameter int BURST      = DEF_BURST
) (
  input  logic                  rclk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  ren_mon,
  output logic                  wen,
  output logic [DATA_WIDTH-1:0] din,
  output logic [ADD_WIDTH:0]    level,
  output logic                  full,
  output logic                  empty,
  output logic                  burst_done,
  output logic                  err
);

  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BW-1:0] LAST = BW'(BURST - 1);
  localparam logic [BW-1:0] BONE = BW'(1);
  localparam logic [ADD_WIDTH:0] LOC_V = (ADD_WIDTH+1)'(LOC);
  localparam logic [ADD_WIDTH:0] BST_V = (ADD_WIDTH+1)'(BURST);

  wr_state_e     state, state_n;
  logic [BW-1:0] beat, beat_n;
  logic          acc;
  logic          admit;
  logic          udf;
  logic          ovf;

  assign acc   = s_valid && s_ready;
  // level never exceeds LOC, so the subtraction cannot wrap
  assign admit = (LOC_V - level) >= BST_V;

  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      beat  <= '0;
    end else begin
      state <= state_n;
      beat  <= beat_n;
    end
  end

  always_comb begin
    state_n    = state;
    beat_n     = beat;
    s_ready    = 1'b0;
    burst_done = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (s_valid && admit) state_n = S_BURST;
      end
      S_BURST: begin
        s_ready = 1'b1;
        if (acc) begin
          if (beat == LAST) begin
            beat_n  = '0;
            state_n = S_DONE;
          end else begin
            beat_n = beat + BONE;
          end
        end
      end
      S_DONE: begin
        burst_done = 1'b1;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      wen <= 1'b0;
      din <= '0;
    end else begin
      wen <= acc;
      if (acc) din <= s_data;
    end
  end

  mem2_level_ctr #(
    .LOC (LOC),
    .AW  (ADD_WIDTH)
  ) u_lvl (
    .rclk  (rclk),
    .rst   (rst),
    .inc   (acc),
    .dec   (ren_mon),
    .level (level),
    .full  (full),
    .empty (empty),
    .udf   (udf),
    .ovf   (ovf)
  );

`ifdef MEM2_WR_OVF_CHK_EN
  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (udf || ovf) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_chk;
  assign unused_chk = udf ^ ovf;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_mem2_burst_writer.sv
// Self-checking bench for mem2_burst_writer: vector table, directed
// corner sequences and randomized traffic against a behavioural model.
module tb_mem2_burst_writer;

  localparam int DW    = 32;
  localparam int LOC   = 64;
  localparam int AW    = 6;
  localparam int BURST = 8;

`ifdef MEM2_WR_OVF_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          rclk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          ren_mon = 1'b0;
  logic          wen;
  logic [DW-1:0] din;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          burst_done;
  logic          err;

  mem2_burst_writer #(
    .DATA_WIDTH (DW),
    .LOC        (LOC),
    .ADD_WIDTH  (AW),
    .BURST      (BURST)
  ) dut (
    .rclk       (rclk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .ren_mon    (ren_mon),
    .wen        (wen),
    .din        (din),
    .level      (level),
    .full       (full),
    .empty      (empty),
    .burst_done (burst_done),
    .err        (err)
  );

  always #5 rclk = ~rclk;

  int n_chk  = 0;
  int n_fail = 0;

  // behavioural model: is a burst open, how many words it still owes
  int          m_level;
  bit          m_inb;
  int          m_left;
  bit          m_done;
  bit          m_wen;
  logic [DW-1:0] m_din;
  bit          m_err;
  int          wcnt;

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_level = 0;
    m_inb   = 0;
    m_left  = 0;
    m_done  = 0;
    m_wen   = 0;
    m_din   = '0;
    m_err   = 0;
  endtask

  task automatic model_step(bit v, logic [DW-1:0] d, bit r);
    bit acc;
    int old;
    acc = m_inb && v;
    old = m_level;
    if (r && old == 0 && CHK_EN) m_err = 1;
    if (acc && !r) m_level = old + 1;
    else if (r && !acc && old > 0) m_level = old - 1;
    m_wen = acc;
    if (acc) m_din = d;
    if (m_done) begin
      m_done = 0;
    end else if (!m_inb) begin
      if (v && (LOC - old) >= BURST) begin
        m_inb  = 1;
        m_left = BURST;
      end
    end else if (acc) begin
      m_left--;
      if (m_left == 0) begin
        m_inb  = 0;
        m_done = 1;
      end
    end
  endtask

  task automatic check_all(string t);
    chk({t, ".level"}, DW'(level), DW'(m_level));
    chk({t, ".wen"}, DW'(wen), DW'(m_wen));
    chk({t, ".din"}, din, m_din);
    chk({t, ".done"}, DW'(burst_done), DW'(m_done));
    chk({t, ".full"}, DW'(full), DW'(m_level == LOC));
    chk({t, ".empty"}, DW'(empty), DW'(m_level == 0));
    chk({t, ".err"}, DW'(err), DW'(m_err));
    chk({t, ".ready"}, DW'(s_ready), DW'(m_inb));
  endtask

  task automatic cycle(string t, bit v, logic [DW-1:0] d, bit r);
    s_valid = v;
    s_data  = d;
    ren_mon = r;
    #1;
    chk({t, ".ready_pre"}, DW'(s_ready), DW'(m_inb));
    @(posedge rclk);
    #1;
    model_step(v, d, r);
    if (wen) wcnt++;
    check_all(t);
  endtask

  task automatic do_reset();
    s_valid = 0;
    ren_mon = 0;
    rst = 0;
    #1;
    model_reset();
    check_all("reset");
    @(posedge rclk);
    #1;
    rst = 1;
  endtask

  task automatic run_burst(string t, logic [DW-1:0] base);
    cycle(t, 1, base, 0);
    for (int i = 0; i < BURST; i++) cycle(t, 1, base + DW'(i), 0);
    cycle(t, 0, '0, 0);
  endtask

  typedef struct {
    bit            v;
    logic [DW-1:0] d;
    bit            e_wen;
    logic [DW-1:0] e_din;
    int            e_level;
    bit            e_rdy;
    bit            e_done;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0].v = 1; tbl[0].d = 32'h10; tbl[0].e_wen = 0;
    tbl[0].e_din = '0; tbl[0].e_level = 0;
    tbl[0].e_rdy = 1; tbl[0].e_done = 0;
    for (int k = 1; k <= 8; k++) begin
      tbl[k].v       = 1;
      tbl[k].d       = 32'h10 + DW'(k - 1);
      tbl[k].e_wen   = 1;
      tbl[k].e_din   = 32'h10 + DW'(k - 1);
      tbl[k].e_level = k;
      tbl[k].e_rdy   = (k < 8);
      tbl[k].e_done  = (k == 8);
    end
    tbl[9].v = 0; tbl[9].d = '0; tbl[9].e_wen = 0;
    tbl[9].e_din = 32'h17; tbl[9].e_level = 8;
    tbl[9].e_rdy = 0; tbl[9].e_done = 0;

    wcnt = 0;
    repeat (2) @(posedge rclk);
    #1;
    do_reset();

    // single burst, table driven
    for (int i = 0; i < 10; i++) begin
      cycle("tbl", tbl[i].v, tbl[i].d, 0);
      chk($sformatf("tbl%0d.wen", i), DW'(wen), DW'(tbl[i].e_wen));
      chk($sformatf("tbl%0d.din", i), din, tbl[i].e_din);
      chk($sformatf("tbl%0d.lvl", i), DW'(level), DW'(tbl[i].e_level));
      chk($sformatf("tbl%0d.rdy", i), DW'(s_ready), DW'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d.done", i), DW'(burst_done), DW'(tbl[i].e_done));
    end

    // stall for 3 cycles after beat 3
    do_reset();
    wcnt = 0;
    cycle("stall", 1, '0, 0);
    for (int i = 0; i < 4; i++) cycle("stall", 1, 32'h40 + DW'(i), 0);
    for (int i = 0; i < 3; i++) cycle("stall", 0, 32'hdead, 0);
    for (int i = 4; i < 8; i++) cycle("stall", 1, 32'h40 + DW'(i), 0);
    cycle("stall", 0, '0, 0);
    chk("stall.words", DW'(wcnt), DW'(8));
    chk("stall.level", DW'(level), DW'(8));

    // space blocking at level 57
    do_reset();
    for (int b = 0; b < 8; b++) run_burst("fill", DW'(b * 16));
    chk("fill.full", DW'(full), DW'(1));
    for (int i = 0; i < 7; i++) cycle("drain", 0, '0, 1);
    chk("block.level", DW'(level), DW'(57));
    for (int i = 0; i < 4; i++) begin
      cycle("block", 1, 32'h99, 0);
      chk("block.ready", DW'(s_ready), DW'(0));
    end
    cycle("block", 1, 32'h99, 1);
    chk("block.l56", DW'(level), DW'(56));
    cycle("block", 1, 32'h99, 0);
    chk("block.go", DW'(s_ready), DW'(1));
    for (int i = 0; i < BURST; i++) cycle("block", 1, DW'(i), 0);
    cycle("block", 0, '0, 0);
    chk("block.end", DW'(level), DW'(64));

    // accept and read together at level 20
    do_reset();
    run_burst("sim", 32'h100);
    run_burst("sim", 32'h200);
    cycle("sim", 1, '0, 0);
    for (int i = 0; i < 4; i++) cycle("sim", 1, DW'(i), 0);
    chk("sim.l20a", DW'(level), DW'(20));
    cycle("sim", 1, 32'h55, 1);
    chk("sim.l20b", DW'(level), DW'(20));
    for (int i = 0; i < 3; i++) cycle("sim", 1, DW'(i), 0);
    cycle("sim", 0, '0, 0);

    // asynchronous reset during beat 5
    do_reset();
    cycle("mid", 1, '0, 0);
    for (int i = 0; i < 5; i++) cycle("mid", 1, 32'h70 + DW'(i), 0);
    s_valid = 1;
    s_data  = 32'h75;
    rst = 0;
    #1;
    model_reset();
    check_all("midrst");
    @(posedge rclk);
    #1;
    rst = 1;
    wcnt = 0;
    run_burst("post", 32'h300);
    chk("post.words", DW'(wcnt), DW'(8));
    chk("post.level", DW'(level), DW'(8));
    chk("post.din", din, 32'h307);

    // underflow
    do_reset();
    cycle("udf", 0, '0, 1);
    chk("udf.err", DW'(err), DW'(CHK_EN));
    chk("udf.level", DW'(level), DW'(0));
    cycle("udf", 0, '0, 0);
    chk("udf.sticky", DW'(err), DW'(CHK_EN));

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle("rnd", $urandom_range(0, 99) < 70, $urandom,
            $urandom_range(0, 99) < 25);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
